// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Default 640x480 timing constants and shared types for the raster.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  typedef logic [9:0] coord_t;
  typedef logic [5:0] rgb_t;

  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_MAX_TOTAL = 1024;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Raster/colour bus between the timing generator and its consumers.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic        en;
  coord_t      col;
  coord_t      row;
  logic        valid;
  logic        line_start;
  logic        frame_start;
  rgb_t        rgb_in;
  rgb_t        rgb_out;
  logic        hsync;
  logic        vsync;
  logic [15:0] frame_count;

  modport master (
    input  en, rgb_in,
    output col, row, valid, line_start, frame_start,
    output rgb_out, hsync, vsync, frame_count
  );

  modport slave (
    output en, rgb_in,
    input  col, row, valid, line_start, frame_start,
    input  rgb_out, hsync, vsync, frame_count
  );

endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Brief    : One raster axis: wrapping position counter with active/sync flags.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic step,
  output coord_t    count,
  output logic      wrap,
  output logic      in_active,
  output logic      in_sync
);

  localparam int     TOTAL  = ACTIVE + FP + SYNC + BP;
  localparam coord_t C_LAST = coord_t'(TOTAL - 1);

  generate
    if (TOTAL > VGA_MAX_TOTAL) begin : g_total_check
      $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, VGA_MAX_TOTAL);
    end
  endgenerate

  coord_t count_q, count_d;
  logic   sync_q, sync_d;

  assign wrap = (count_q == C_LAST);

  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + coord_t'(1);
    end
  end

  // in_active looks at the position about to be loaded so the owner can
  // register it alongside the count; in_sync describes the current count.
  assign in_active = (int'(count_d) < ACTIVE);
  assign sync_d    = (int'(count_d) >= ACTIVE + FP) && (int'(count_d) < ACTIVE + FP + SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= C_LAST;
      sync_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count   = count_q;
  assign in_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480 raster timing, registered colour/sync output stage.
//            Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  wire logic clk,
  input  wire logic rst,
  vga_timing_gen_if.master bus
);

  coord_t h_count, v_count;
  logic   h_wrap, h_active, h_sync;
  logic   v_wrap, v_active, v_sync;
  logic   v_step;

  assign v_step = bus.en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .step      (bus.en),
    .count     (h_count),
    .wrap      (h_wrap),
    .in_active (h_active),
    .in_sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .step      (v_step),
    .count     (v_count),
    .wrap      (v_wrap),
    .in_active (v_active),
    .in_sync   (v_sync)
  );

  logic valid_q, valid_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  rgb_t rgb_q, rgb_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;

  // Stage 1 flags follow the counters' next position; stage 2 samples the
  // current stage 1 position so colour and sync leave together.
  assign valid_d       = h_active & v_active;
  assign line_start_d  = h_wrap;
  assign frame_start_d = h_wrap & v_wrap;
  assign rgb_d         = valid_q ? bus.rgb_in : '0;
  assign hsync_d       = ~h_sync;
  assign vsync_d       = ~v_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
    end else if (bus.en) begin
      valid_q       <= valid_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (bus.en && frame_start_d) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.frame_count = frame_cnt_q;
`else
  assign bus.frame_count = '0;
`endif

  assign bus.col         = h_count;
  assign bus.row         = v_count;
  assign bus.valid       = valid_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.rgb_out     = rgb_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed vector bench for vga_timing_gen (short vertical timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
  import vga_pkg::*;

  // Horizontal timing is the real 800-clock line; the frame is shortened to
  // 12 lines (sync on rows 8..9) so several frames fit in a short run.
  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int FRAME = 800 * (VA + VF + VS + VB);
  localparam logic [5:0] R = 6'b110000;

  typedef struct {
    int         k;
    int         col;
    int         row;
    logic       valid;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [5:0] rgb;
    int         fc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int k     = 0;
  vec_t tbl [22];

  function automatic int fc_exp(input int n);
`ifdef VGA_TIMING_FRAME_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic e);
    bus.en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v);
    chk($sformatf("k%0d col", v.k),         int'(bus.col),         v.col);
    chk($sformatf("k%0d row", v.k),         int'(bus.row),         v.row);
    chk($sformatf("k%0d valid", v.k),       int'(bus.valid),       int'(v.valid));
    chk($sformatf("k%0d line_start", v.k),  int'(bus.line_start),  int'(v.ls));
    chk($sformatf("k%0d frame_start", v.k), int'(bus.frame_start), int'(v.fs));
    chk($sformatf("k%0d hsync", v.k),       int'(bus.hsync),       int'(v.hs));
    chk($sformatf("k%0d vsync", v.k),       int'(bus.vsync),       int'(v.vs));
    chk($sformatf("k%0d rgb_out", v.k),     int'(bus.rgb_out),     int'(v.rgb));
    chk($sformatf("k%0d frame_count", v.k), int'(bus.frame_count), fc_exp(v.fc));
  endtask

  initial begin
    int hs_run, hs_runs, hs_bad, vs_low, vs_runs, val_cnt;
    logic vs_prev;

    //           k     col  row v  ls fs hs vs rgb    fc
    tbl[0]  = '{0,     799, 11, 0, 0, 0, 1, 1, 6'd0, 0};
    tbl[1]  = '{1,     0,   0,  1, 1, 1, 1, 1, 6'd0, 1};
    tbl[2]  = '{2,     1,   0,  1, 0, 0, 1, 1, R,    1};
    tbl[3]  = '{640,   639, 0,  1, 0, 0, 1, 1, R,    1};
    tbl[4]  = '{641,   640, 0,  0, 0, 0, 1, 1, R,    1};
    tbl[5]  = '{642,   641, 0,  0, 0, 0, 1, 1, 6'd0, 1};
    tbl[6]  = '{657,   656, 0,  0, 0, 0, 1, 1, 6'd0, 1};
    tbl[7]  = '{658,   657, 0,  0, 0, 0, 0, 1, 6'd0, 1};
    tbl[8]  = '{753,   752, 0,  0, 0, 0, 0, 1, 6'd0, 1};
    tbl[9]  = '{754,   753, 0,  0, 0, 0, 1, 1, 6'd0, 1};
    tbl[10] = '{800,   799, 0,  0, 0, 0, 1, 1, 6'd0, 1};
    tbl[11] = '{801,   0,   1,  1, 1, 0, 1, 1, 6'd0, 1};
    tbl[12] = '{802,   1,   1,  1, 0, 0, 1, 1, R,    1};
    tbl[13] = '{4640,  639, 5,  1, 0, 0, 1, 1, R,    1};
    tbl[14] = '{4801,  0,   6,  0, 1, 0, 1, 1, 6'd0, 1};
    tbl[15] = '{4802,  1,   6,  0, 0, 0, 1, 1, 6'd0, 1};
    tbl[16] = '{6401,  0,   8,  0, 1, 0, 1, 1, 6'd0, 1};
    tbl[17] = '{6402,  1,   8,  0, 0, 0, 1, 0, 6'd0, 1};
    tbl[18] = '{8001,  0,   10, 0, 1, 0, 1, 0, 6'd0, 1};
    tbl[19] = '{8002,  1,   10, 0, 0, 0, 1, 1, 6'd0, 1};
    tbl[20] = '{9600,  799, 11, 0, 0, 0, 1, 1, 6'd0, 1};
    tbl[21] = '{9601,  0,   0,  1, 1, 1, 1, 1, 6'd0, 2};

    bus.en     = 1'b1;
    bus.rgb_in = R;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_vec(tbl[0]);
    rst = 1'b0;

    for (int i = 1; i < 22; i++) begin
      while (k < tbl[i].k) begin
        tick(1'b1);
        k++;
      end
      check_vec(tbl[i]);
    end

    // One full frame: sync pulse widths and active pixel count.
    hs_run = 0; hs_runs = 0; hs_bad = 0; vs_low = 0; vs_runs = 0; val_cnt = 0;
    vs_prev = 1'b1;
    for (int n = 0; n < FRAME; n++) begin
      tick(1'b1);
      k++;
      if (bus.hsync == 1'b0) begin
        hs_run++;
      end else if (hs_run != 0) begin
        if (hs_run != 96) hs_bad++;
        hs_runs++;
        hs_run = 0;
      end
      if (bus.vsync == 1'b0) vs_low++;
      if (vs_prev && !bus.vsync) vs_runs++;
      vs_prev = bus.vsync;
      if (bus.valid) val_cnt++;
    end
    chk("hsync pulse count", hs_runs, 12);
    chk("hsync pulse not 96 wide", hs_bad, 0);
    chk("vsync low cycles", vs_low, 1600);
    chk("vsync pulse count", vs_runs, 1);
    chk("valid pixel count", val_cnt, 640 * VA);
    chk("frame2 col", int'(bus.col), 0);
    chk("frame2 row", int'(bus.row), 0);
    chk("frame2 frame_start", int'(bus.frame_start), 1);
    chk("frame2 frame_count", int'(bus.frame_count), fc_exp(3));

    // en on every other clock; rgb_in changes while en=0 must not be captured.
    for (int i = 0; i < 10; i++) begin
      bus.rgb_in = R;
      tick(1'b1);
      k++;
      chk($sformatf("en1 step%0d col", i), int'(bus.col), i + 1);
      chk($sformatf("en1 step%0d rgb", i), int'(bus.rgb_out), int'(R));
      bus.rgb_in = 6'd0;
      tick(1'b0);
      chk($sformatf("en0 step%0d col", i), int'(bus.col), i + 1);
      chk($sformatf("en0 step%0d row", i), int'(bus.row), 0);
      chk($sformatf("en0 step%0d rgb", i), int'(bus.rgb_out), int'(R));
      chk($sformatf("en0 step%0d valid", i), int'(bus.valid), 1);
    end
    bus.rgb_in = R;

    // Walk to (700,3), inside the hsync pulse, then reset.
    for (int n = 0; n < 3 * 800 + 700 - 10; n++) tick(1'b1);
    chk("pre-reset col", int'(bus.col), 700);
    chk("pre-reset row", int'(bus.row), 3);
    chk("pre-reset hsync", int'(bus.hsync), 0);
    rst = 1'b1;
    tick(1'b1);
    chk("reset col", int'(bus.col), 799);
    chk("reset row", int'(bus.row), 11);
    chk("reset valid", int'(bus.valid), 0);
    chk("reset line_start", int'(bus.line_start), 0);
    chk("reset frame_start", int'(bus.frame_start), 0);
    chk("reset rgb_out", int'(bus.rgb_out), 0);
    chk("reset hsync", int'(bus.hsync), 1);
    chk("reset vsync", int'(bus.vsync), 1);
    chk("reset frame_count", int'(bus.frame_count), 0);
    rst = 1'b0;
    tick(1'b1);
    chk("post-reset col", int'(bus.col), 0);
    chk("post-reset row", int'(bus.row), 0);
    chk("post-reset frame_start", int'(bus.frame_start), 1);
    chk("post-reset frame_count", int'(bus.frame_count), fc_exp(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
